alarm_chime_ctrl: RTL and testbench

//  Request generator for the buzzer tone driver: decides when the buzzer beeps.
//  - Drives shouldTick for the hourly chime.
//  - Drives isTimeUp while the alarm rings.
//  - Watches BCD time from the timekeeper and the user alarm setting; the user can acknowledge.
//  - Sits between the clock counters/key debouncer and the buzzer.

---
 rtl/alarm_chime_ctrl_if.sv | 23 ++
 rtl/alarm_chime_ctrl.sv | 119 +++++++++++
 tb/tb_alarm_chime_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/alarm_chime_ctrl_if.sv
// alarm_chime_ctrl_if: BCD time, alarm settings and buzzer requests between timekeeper and chime controller
interface alarm_chime_ctrl_if;
  logic       cp_1hz;
  logic [7:0] hour;
  logic [7:0] minute;
  logic [7:0] second;
  logic [7:0] alarm_hour;
  logic [7:0] alarm_min;
  logic       alarm_en;
  logic       chime_en;
  logic       ack;
  logic       should_tick;
  logic       is_time_up;
  logic       ringing;
  modport master (
    output cp_1hz, hour, minute, second, alarm_hour, alarm_min, alarm_en, chime_en, ack,
    input  should_tick, is_time_up, ringing
  );
  modport slave (
    input  cp_1hz, hour, minute, second, alarm_hour, alarm_min, alarm_en, chime_en, ack,
    output should_tick, is_time_up, ringing
  );
endinterface

// File: rtl/alarm_chime_ctrl.sv
// alarm_chime_ctrl: hourly chime and alarm request generator for the buzzer; SNOOZE_EN builds the snooze feature
module alarm_chime_ctrl #(
  parameter logic [7:0] CHIME_START = 8'h55,
  parameter logic [6:0] RING_SECS   = 7'd60
`ifdef SNOOZE_EN
  ,
  parameter logic [8:0] SNOOZE_SECS = 9'd300,
  parameter logic [1:0] MAX_SNOOZE  = 2'd3
`endif
) (
  input logic               clk_i,
  input logic               nrst_i,
  alarm_chime_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef SNOOZE_EN
    SNOOZE = 2'd2,
`endif
    RING   = 2'd1
  } state_e;
  state_e     state_q, state_d;
  logic       sec_stb_q;
  logic [6:0] ring_cnt_q, ring_cnt_d;
  logic       should_tick_q, should_tick_d;
  logic       is_time_up_q;
  logic       ringing_q;
`ifdef SNOOZE_EN
  logic [8:0] snz_timer_q, snz_timer_d;
  logic [1:0] snooze_cnt_q, snooze_cnt_d;
`endif
  logic       chime_hit;
  logic       alarm_hit;
  assign chime_hit = bus.chime_en && bus.minute == 8'h59 && bus.second >= CHIME_START && bus.second <= 8'h59;
  assign alarm_hit = bus.hour == bus.alarm_hour && bus.minute == bus.alarm_min && bus.second == 8'h00;
  // Alarm FSM next state and counters; ack outranks the second strobe, disarm outranks both
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
`ifdef SNOOZE_EN
    snz_timer_d  = snz_timer_q;
    snooze_cnt_d = snooze_cnt_q;
`endif
    if (!bus.alarm_en)
      state_d = IDLE;
    else
      case (state_q)
        IDLE:
          if (sec_stb_q && alarm_hit) begin
            state_d    = RING;
            ring_cnt_d = '0;
`ifdef SNOOZE_EN
            snooze_cnt_d = '0;
`endif
          end
        RING:
          if (bus.ack) begin
`ifdef SNOOZE_EN
            state_d     = snooze_cnt_q < MAX_SNOOZE ? SNOOZE : IDLE;
            snz_timer_d = '0;
`else
            state_d = IDLE;
`endif
          end else if (sec_stb_q) begin
            if (ring_cnt_q == RING_SECS - 7'd1)
              state_d = IDLE;
            else
              ring_cnt_d = ring_cnt_q + {6'd0, ring_cnt_q != 7'h7f};
          end
`ifdef SNOOZE_EN
        SNOOZE:
          if (bus.ack)
            state_d = IDLE;
          else if (sec_stb_q) begin
            if (snz_timer_q == SNOOZE_SECS - 9'd1) begin
              state_d      = RING;
              ring_cnt_d   = '0;
              snooze_cnt_d = snooze_cnt_q + {1'b0, snooze_cnt_q != 2'h3};
            end else
              snz_timer_d = snz_timer_q + {8'd0, snz_timer_q != 9'h1ff};
          end
`endif
        default: state_d = IDLE;
      endcase
  end
  // Chime request: sampled on each strobe and held between strobes, suppressed by ringing or chime disable
  always_comb begin
    should_tick_d = (state_d == RING || !bus.chime_en) ? 1'b0 : sec_stb_q ? chime_hit : should_tick_q;
  end
  // State, strobe delay and registered outputs
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state_q       <= IDLE;
      sec_stb_q     <= 1'b0;
      ring_cnt_q    <= '0;
      should_tick_q <= 1'b0;
      is_time_up_q  <= 1'b0;
      ringing_q     <= 1'b0;
`ifdef SNOOZE_EN
      snz_timer_q  <= '0;
      snooze_cnt_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      sec_stb_q     <= bus.cp_1hz;
      ring_cnt_q    <= ring_cnt_d;
      should_tick_q <= should_tick_d;
      is_time_up_q  <= state_d == RING;
      ringing_q     <= state_d == RING;
`ifdef SNOOZE_EN
      snz_timer_q  <= snz_timer_d;
      snooze_cnt_q <= snooze_cnt_d;
`endif
    end
  end
  assign bus.should_tick = should_tick_q;
  assign bus.is_time_up  = is_time_up_q;
  assign bus.ringing     = ringing_q;
endmodule

// File: tb/tb_alarm_chime_ctrl.sv
// tb_alarm_chime_ctrl: table-driven chime/alarm vectors plus timeout, reset and acknowledge sequences
module tb_alarm_chime_ctrl;
  logic clk = 1'b0;
  logic nrst;
  int   total = 0;
  int   passed = 0;
  alarm_chime_ctrl_if bus ();
`ifdef SNOOZE_EN
  alarm_chime_ctrl #(.SNOOZE_SECS(9'd5), .MAX_SNOOZE(2'd3)) dut (.clk_i(clk), .nrst_i(nrst), .bus(bus));
`else
  alarm_chime_ctrl dut (.clk_i(clk), .nrst_i(nrst), .bus(bus));
`endif
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    logic       aen;
    logic       cen;
    logic [2:0] exp;
  } vec_t;
  vec_t v[16];
  function automatic logic [7:0] bcd(input int n);
    return 8'((n / 10) * 16 + n % 10);
  endfunction
  function automatic int outs();
    return int'({bus.should_tick, bus.is_time_up, bus.ringing});
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask
  task automatic sec(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    bus.hour = h;
    bus.minute = m;
    bus.second = s;
    bus.cp_1hz = 1'b1;
    @(posedge clk);
    #1 bus.cp_1hz = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic press();
    bus.ack = 1'b1;
    @(posedge clk);
    #1 bus.ack = 1'b0;
  endtask
  initial begin
    int cnt;
    int sn;
    v[0]  = '{8'h10, 8'h59, 8'h54, 1'b0, 1'b1, 3'b000};
    v[1]  = '{8'h10, 8'h59, 8'h55, 1'b0, 1'b1, 3'b100};
    v[2]  = '{8'h10, 8'h59, 8'h56, 1'b0, 1'b1, 3'b100};
    v[3]  = '{8'h10, 8'h59, 8'h59, 1'b0, 1'b1, 3'b100};
    v[4]  = '{8'h11, 8'h00, 8'h00, 1'b0, 1'b1, 3'b000};
    v[5]  = '{8'h10, 8'h59, 8'h57, 1'b0, 1'b0, 3'b000};
    v[6]  = '{8'h10, 8'h58, 8'h56, 1'b0, 1'b1, 3'b000};
    v[7]  = '{8'h13, 8'h00, 8'h00, 1'b1, 1'b1, 3'b000};
    v[8]  = '{8'h12, 8'h00, 8'h05, 1'b1, 1'b1, 3'b000};
    v[9]  = '{8'h11, 8'h59, 8'h55, 1'b1, 1'b1, 3'b100};
    v[10] = '{8'h11, 8'h59, 8'h59, 1'b1, 1'b1, 3'b100};
    v[11] = '{8'h12, 8'h00, 8'h00, 1'b1, 1'b1, 3'b011};
    v[12] = '{8'h12, 8'h00, 8'h01, 1'b1, 1'b1, 3'b011};
    v[13] = '{8'h12, 8'h00, 8'h00, 1'b1, 1'b1, 3'b011};
    v[14] = '{8'h11, 8'h59, 8'h56, 1'b1, 1'b1, 3'b011};
    v[15] = '{8'h11, 8'h59, 8'h57, 1'b0, 1'b1, 3'b100};
    nrst = 1'b0;
    bus.cp_1hz = 1'b0;
    bus.hour = 8'h00;
    bus.minute = 8'h00;
    bus.second = 8'h01;
    bus.alarm_hour = 8'h12;
    bus.alarm_min = 8'h00;
    bus.alarm_en = 1'b0;
    bus.chime_en = 1'b0;
    bus.ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset_state", outs(), 0);
    nrst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.alarm_en = v[i].aen;
      bus.chime_en = v[i].cen;
      sec(v[i].h, v[i].m, v[i].s);
      chk($sformatf("vec%0d", i), outs(), int'(v[i].exp));
    end
    bus.alarm_en = 1'b0;
    bus.chime_en = 1'b1;
    sec(8'h10, 8'h59, 8'h54);
    bus.hour = 8'h10;
    bus.minute = 8'h59;
    bus.second = 8'h55;
    bus.cp_1hz = 1'b1;
    @(posedge clk);
    #1 bus.cp_1hz = 1'b0;
    chk("chime_latency_1clk", int'(bus.should_tick), 0);
    @(posedge clk);
    #1 chk("chime_latency_2clk", int'(bus.should_tick), 1);
    repeat (4) @(posedge clk);
    #1 chk("chime_hold", int'(bus.should_tick), 1);
    bus.chime_en = 1'b0;
    @(posedge clk);
    #1 chk("chime_disable", int'(bus.should_tick), 0);
    bus.alarm_hour = 8'h07;
    bus.alarm_min = 8'h30;
    bus.alarm_en = 1'b1;
    sec(8'h07, 8'h29, 8'h59);
    chk("before_alarm", outs(), 0);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      sec(8'h07, 8'h30, bcd(i));
      if (bus.is_time_up) cnt++;
    end
    chk("ring_length", cnt, 60);
    sec(8'h07, 8'h31, 8'h00);
    chk("ring_timeout", outs(), 0);
    sec(8'h07, 8'h30, 8'h00);
    chk("ring_again", outs(), 3);
    nrst = 1'b0;
    @(posedge clk);
    #1 chk("reset_mid_ring", outs(), 0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    sec(8'h07, 8'h30, 8'h01);
    chk("no_resume", outs(), 0);
    sec(8'h07, 8'h30, 8'h00);
    chk("ring_for_ack", outs(), 3);
    sec(8'h07, 8'h30, 8'h01);
    sec(8'h07, 8'h30, 8'h02);
    press();
    chk("ack_stops", outs(), 0);
`ifdef SNOOZE_EN
    sn = 3;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) press();
      if (k > 0) chk($sformatf("ack%0d_stops", k + 1), outs(), 0);
      cnt = 0;
      for (int j = 0; j < (k < 3 ? 4 : 6); j++) begin
        sec(8'h07, 8'h30, bcd(sn));
        sn++;
        if (bus.is_time_up) cnt++;
      end
      chk($sformatf("snooze%0d_quiet", k + 1), cnt, 0);
      if (k < 3) begin
        sec(8'h07, 8'h30, bcd(sn));
        sn++;
        chk($sformatf("snooze%0d_rering", k + 1), outs(), 3);
      end
    end
`else
    sn = 3;
    cnt = 0;
    for (int j = 0; j < 7; j++) begin
      sec(8'h07, 8'h30, bcd(sn));
      sn++;
      if (bus.is_time_up) cnt++;
    end
    chk("ack_stays_idle", cnt, 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
